// File: rtl/anim_frame_seq_if.sv
// Control/status bundle for the animation frame sequencer.
// The master side (controller or bench) drives the playback requests and
// the prescaler reload value; the slave side (the sequencer) returns the
// current frame index together with its status pulses.
interface anim_frame_seq_if #(
  parameter int DIV_W = 24
);
  logic             start;
  logic             stop;
  logic             dir;
  logic             loop;
  logic             pingpong;
  logic [DIV_W-1:0] speed;
  logic [4:0]       frame;
  logic             busy;
  logic             tick;
  logic             done;

  modport master (
    output start, stop, dir, loop, pingpong, speed,
    input  frame, busy, tick, done
  );

  modport slave (
    input  start, stop, dir, loop, pingpong, speed,
    output frame, busy, tick, done
  );
endinterface

// File: rtl/anim_frame_seq.sv
// Animation frame sequencer: steps a 5-bit frame index (0..31) that feeds a
// 7-segment pattern decoder, holding each frame for speed+1 clock cycles.
// Plays forward or in reverse, either once or endlessly.
// Optional feature: define ANIM_PINGPONG_EN to make the ends bounce instead
// of wrap when pingpong is latched high at start. Without the macro the
// pingpong input is accepted but has no effect.
module anim_frame_seq #(
  parameter int DIV_W = 24
) (
  input logic              clk,
  input logic              rst,
  anim_frame_seq_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_n;
  logic [4:0]       frame_q, frame_n;
  logic [DIV_W-1:0] count_q, count_n;
  logic             dir_q, dir_n;
  logic             loop_q, loop_n;
  logic             busy_q, busy_n;
  logic             tick_q, tick_n;
  logic             done_q, done_n;
  logic             at_end;
  logic [4:0]       next_frame;

`ifdef ANIM_PINGPONG_EN
  // pp_q: bounce mode latched at start; ret_q: the first end has been reached
  logic             pp_q, pp_n;
  logic             ret_q, ret_n;
`else
  logic             unused_pingpong;
  assign unused_pingpong = bus.pingpong;
`endif

  // Next-state and datapath decisions for the IDLE/RUN controller
  always_comb begin
    state_n    = state_q;
    frame_n    = frame_q;
    count_n    = count_q;
    dir_n      = dir_q;
    loop_n     = loop_q;
    tick_n     = 1'b0;
    done_n     = 1'b0;
`ifdef ANIM_PINGPONG_EN
    pp_n       = pp_q;
    ret_n      = ret_q;
`endif
    at_end     = dir_q ? (frame_q == 5'd0) : (frame_q == 5'd31);
    next_frame = dir_q ? (frame_q - 5'd1) : (frame_q + 5'd1);

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          state_n = RUN;
          frame_n = bus.dir ? 5'd31 : 5'd0;
          count_n = bus.speed;
          dir_n   = bus.dir;
          loop_n  = bus.loop;
`ifdef ANIM_PINGPONG_EN
          pp_n    = bus.pingpong;
          ret_n   = 1'b0;
`endif
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_n = IDLE;
        end else if (count_q != '0) begin
          count_n = count_q - DIV_W'(1);
        end else begin
          count_n = bus.speed;
`ifdef ANIM_PINGPONG_EN
          if (at_end && pp_q) begin
            if (ret_q && !loop_q) begin
              state_n = IDLE;
              done_n  = 1'b1;
            end else begin
              dir_n   = ~dir_q;
              ret_n   = 1'b1;
              frame_n = dir_q ? (frame_q + 5'd1) : (frame_q - 5'd1);
              tick_n  = 1'b1;
            end
          end else
`endif
          if (at_end && !loop_q) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            frame_n = next_frame;
            tick_n  = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n == RUN);
  end

  // State, frame, prescaler and status registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      frame_q <= 5'd0;
      count_q <= '0;
      dir_q   <= 1'b0;
      loop_q  <= 1'b0;
      busy_q  <= 1'b0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef ANIM_PINGPONG_EN
      pp_q    <= 1'b0;
      ret_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      frame_q <= frame_n;
      count_q <= count_n;
      dir_q   <= dir_n;
      loop_q  <= loop_n;
      busy_q  <= busy_n;
      tick_q  <= tick_n;
      done_q  <= done_n;
`ifdef ANIM_PINGPONG_EN
      pp_q    <= pp_n;
      ret_q   <= ret_n;
`endif
    end
  end

  assign bus.frame = frame_q;
  assign bus.busy  = busy_q;
  assign bus.tick  = tick_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_anim_frame_seq.sv
// Self-checking bench for anim_frame_seq: a per-cycle vector table followed
// by hand-written multi-cycle playback sequences (wrap, one-shot, reverse,
// stop, mid-play reset and the optional ANIM_PINGPONG_EN bounce).
module tb_anim_frame_seq;

  localparam int DIV_W = 24;

  typedef struct {
    logic             rst;
    logic             start;
    logic             stop;
    logic             dir;
    logic             loop;
    logic             pp;
    logic [DIV_W-1:0] speed;
    logic [4:0]       frame;
    logic             busy;
    logic             tick;
    logic             done;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  vec_t vecs[$];

  anim_frame_seq_if #(.DIV_W(DIV_W)) bus ();

  anim_frame_seq #(.DIV_W(DIV_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic stepCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic addVec(input logic r, input logic s, input logic p, input logic d,
                        input logic l, input logic pp, input int spd,
                        input int ef, input logic eb, input logic et, input logic ed);
    vec_t v;
    v.rst = r; v.start = s; v.stop = p; v.dir = d; v.loop = l; v.pp = pp;
    v.speed = DIV_W'(spd);
    v.frame = 5'(ef); v.busy = eb; v.tick = et; v.done = ed;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    rst          = v.rst;
    bus.start    = v.start;
    bus.stop     = v.stop;
    bus.dir      = v.dir;
    bus.loop     = v.loop;
    bus.pingpong = v.pp;
    bus.speed    = v.speed;
  endtask

  task automatic checkOutput(input string name, input int ef, input logic eb,
                             input logic et, input logic ed);
    checks++;
    if (bus.frame !== 5'(ef) || bus.busy !== eb || bus.tick !== et || bus.done !== ed) begin
      errors++;
      $display("[TB] FAIL %s: got frame=%0d busy=%0b tick=%0b done=%0b, expected frame=%0d busy=%0b tick=%0b done=%0b",
               name, bus.frame, bus.busy, bus.tick, bus.done, ef, eb, et, ed);
    end
  endtask

  task automatic doReset();
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    stepCycle();
    rst       = 1'b0;
  endtask

  task automatic startPlay(input logic d, input logic l, input logic pp, input int spd);
    bus.start    = 1'b1;
    bus.stop     = 1'b0;
    bus.dir      = d;
    bus.loop     = l;
    bus.pingpong = pp;
    bus.speed    = DIV_W'(spd);
    stepCycle();
    bus.start    = 1'b0;
  endtask

  initial begin
    int ef;
    int pos;
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.dir      = 1'b0;
    bus.loop     = 1'b0;
    bus.pingpong = 1'b0;
    bus.speed    = '0;

    // rst start stop dir loop pp speed | frame busy tick done
    addVec(1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    addVec(0, 1, 1, 1, 0, 0, 3,   0, 0, 0, 0);
    addVec(0, 1, 0, 0, 1, 0, 3,   0, 1, 0, 0);
    addVec(0, 0, 0, 0, 1, 0, 3,   0, 1, 0, 0);
    addVec(0, 0, 0, 0, 1, 0, 3,   0, 1, 0, 0);
    addVec(0, 0, 0, 0, 1, 0, 3,   0, 1, 0, 0);
    addVec(0, 0, 0, 0, 1, 0, 3,   1, 1, 1, 0);
    addVec(0, 0, 0, 0, 1, 0, 3,   1, 1, 0, 0);
    addVec(0, 0, 0, 0, 1, 0, 3,   1, 1, 0, 0);
    addVec(0, 0, 0, 0, 1, 0, 3,   1, 1, 0, 0);
    addVec(0, 1, 0, 1, 0, 0, 3,   2, 1, 1, 0);
    addVec(0, 0, 0, 1, 0, 0, 3,   2, 1, 0, 0);
    addVec(0, 0, 0, 1, 0, 0, 3,   2, 1, 0, 0);
    addVec(0, 0, 0, 1, 0, 0, 3,   2, 1, 0, 0);
    addVec(0, 0, 0, 1, 0, 0, 0,   3, 1, 1, 0);
    addVec(0, 0, 0, 1, 0, 0, 0,   4, 1, 1, 0);
    addVec(0, 0, 0, 1, 0, 0, 1,   5, 1, 1, 0);
    addVec(0, 0, 0, 1, 0, 0, 1,   5, 1, 0, 0);
    addVec(0, 0, 0, 1, 0, 0, 1,   6, 1, 1, 0);
    addVec(0, 0, 1, 1, 0, 0, 1,   6, 0, 0, 0);
    addVec(0, 0, 0, 1, 0, 0, 1,   6, 0, 0, 0);
    addVec(0, 1, 0, 1, 1, 0, 0,  31, 1, 0, 0);
    addVec(0, 0, 0, 0, 0, 0, 0,  30, 1, 1, 0);
    addVec(0, 0, 0, 0, 0, 0, 0,  29, 1, 1, 0);
    addVec(1, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    addVec(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      stepCycle();
      checkOutput($sformatf("vec%0d", i), vecs[i].frame, vecs[i].busy, vecs[i].tick, vecs[i].done);
    end

    // Forward endless play, 4 cycles per frame, across the 31->0 wrap
    doReset();
    startPlay(1'b0, 1'b1, 1'b0, 3);
    for (int k = 0; k <= 4 * 33; k++) begin
      checkOutput($sformatf("wrap_k%0d", k), (k / 4) % 32, 1'b1, (k > 0) && (k % 4 == 0), 1'b0);
      stepCycle();
    end

    // Forward one-shot at full speed: done one cycle after frame 31
    doReset();
    startPlay(1'b0, 1'b0, 1'b0, 0);
    for (int k = 0; k <= 33; k++) begin
      if (k <= 31)      checkOutput($sformatf("once_k%0d", k), k, 1'b1, k > 0, 1'b0);
      else if (k == 32) checkOutput("once_done", 31, 1'b0, 1'b0, 1'b1);
      else              checkOutput("once_after", 31, 1'b0, 1'b0, 1'b0);
      stepCycle();
    end

    // Reverse one-shot, 2 cycles per frame, ending held at frame 0
    doReset();
    startPlay(1'b1, 1'b0, 1'b0, 1);
    for (int k = 0; k <= 65; k++) begin
      if (k <= 63)      checkOutput($sformatf("rev_k%0d", k), 31 - k / 2, 1'b1, (k > 0) && (k % 2 == 0), 1'b0);
      else if (k == 64) checkOutput("rev_done", 0, 1'b0, 1'b0, 1'b1);
      else              checkOutput("rev_after", 0, 1'b0, 1'b0, 1'b0);
      stepCycle();
    end

    // Stop while showing frame 10, then restart forward from frame 0
    doReset();
    startPlay(1'b0, 1'b1, 1'b0, 0);
    for (int k = 0; k < 10; k++) stepCycle();
    checkOutput("stop_pre", 10, 1'b1, 1'b1, 1'b0);
    bus.stop = 1'b1;
    stepCycle();
    bus.stop = 1'b0;
    checkOutput("stop_hold", 10, 1'b0, 1'b0, 1'b0);
    stepCycle();
    checkOutput("stop_idle", 10, 1'b0, 1'b0, 1'b0);
    startPlay(1'b0, 1'b1, 1'b0, 0);
    checkOutput("stop_restart", 0, 1'b1, 1'b0, 1'b0);

    // Stop on the end-of-play advance wins: no done pulse
    doReset();
    startPlay(1'b0, 1'b0, 1'b0, 0);
    for (int k = 0; k < 31; k++) stepCycle();
    checkOutput("stopend_pre", 31, 1'b1, 1'b1, 1'b0);
    bus.stop = 1'b1;
    stepCycle();
    bus.stop = 1'b0;
    checkOutput("stopend_hold", 31, 1'b0, 1'b0, 1'b0);
    stepCycle();
    checkOutput("stopend_after", 31, 1'b0, 1'b0, 1'b0);

    // Reset while showing frame 17 overrides a pending start
    startPlay(1'b0, 1'b1, 1'b0, 0);
    for (int k = 0; k < 17; k++) stepCycle();
    checkOutput("rst_pre", 17, 1'b1, 1'b1, 1'b0);
    rst       = 1'b1;
    bus.start = 1'b1;
    stepCycle();
    rst       = 1'b0;
    bus.start = 1'b0;
    checkOutput("rst_mid", 0, 1'b0, 1'b0, 1'b0);
    stepCycle();
    checkOutput("rst_after", 0, 1'b0, 1'b0, 1'b0);

    // Pingpong one-shot forward at full speed
    doReset();
    startPlay(1'b0, 1'b0, 1'b1, 0);
`ifdef ANIM_PINGPONG_EN
    for (int k = 0; k <= 64; k++) begin
      ef = (k <= 31) ? k : 62 - k;
      if (k <= 62)      checkOutput($sformatf("pp_k%0d", k), ef, 1'b1, k > 0, 1'b0);
      else if (k == 63) checkOutput("pp_done", 0, 1'b0, 1'b0, 1'b1);
      else              checkOutput("pp_after", 0, 1'b0, 1'b0, 1'b0);
      stepCycle();
    end
`else
    for (int k = 0; k <= 33; k++) begin
      if (k <= 31)      checkOutput($sformatf("pp_k%0d", k), k, 1'b1, k > 0, 1'b0);
      else if (k == 32) checkOutput("pp_done", 31, 1'b0, 1'b0, 1'b1);
      else              checkOutput("pp_after", 31, 1'b0, 1'b0, 1'b0);
      stepCycle();
    end
`endif

    // Pingpong endless play starting in reverse
    doReset();
    startPlay(1'b1, 1'b1, 1'b1, 0);
    for (int k = 0; k <= 70; k++) begin
`ifdef ANIM_PINGPONG_EN
      pos = k % 62;
      ef  = (pos <= 31) ? 31 - pos : pos - 31;
`else
      pos = 0;
      ef  = (31 - k + 64) % 32;
`endif
      checkOutput($sformatf("ppl_k%0d", k), ef, 1'b1, k > 0, 1'b0);
      stepCycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
